// File: rtl/cache_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared constants and types for the cache line / memory
//                burst path. Provides line and beat geometry, the line offset
//                width, and the state encoding of the line/burst adaptor.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Cache line width; equals the data array word size.
    localparam int LINE_WIDTH    = 256;
    // Physical memory beat width.
    localparam int BURST_WIDTH   = 64;
    // Beats per line.
    localparam int BEATS         = LINE_WIDTH / BURST_WIDTH;
    // Byte address width.
    localparam int ADDR_WIDTH    = 32;
    // Byte offset bits within one line.
    localparam int OFFSET_BITS   = $clog2(LINE_WIDTH / 8);
    // Width of the beat counter.
    localparam int BEAT_IDX_BITS = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } adaptor_state_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/line_burst_adaptor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : line_burst_adaptor
//  Description : Bridges the cache's 256-bit line interface to the 64-bit,
//                4-beat memory burst interface. A line fill gathers four
//                memory beats into the fill buffer. A write-back serialises a
//                latched line into four beats. One transaction at a time.
//  Ports       :
//    clk        in   1            clock, rising edge
//    rst        in   1            synchronous active-high reset
//    read_i     in   1            line fill request, held until resp_o
//    write_i    in   1            write-back request, held until resp_o
//    address_i  in   ADDR_WIDTH   request byte address
//    line_i     in   LINE_WIDTH   write-back line, sampled at acceptance
//    line_o     out  LINE_WIDTH   assembled fill line, beat k at [k*64 +: 64]
//    resp_o     out  1            one-cycle completion pulse to the cache
//    address_o  out  ADDR_WIDTH   line-aligned address to memory
//    read_o     out  1            memory read request
//    write_o    out  1            memory write request
//    burst_o    out  BURST_WIDTH  current write beat
//    burst_i    in   BURST_WIDTH  read beat from memory
//    resp_i     in   1            memory beat strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module line_burst_adaptor
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
);

    localparam logic [ADDR_WIDTH-1:0]    c_OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
    localparam logic [BEAT_IDX_BITS-1:0] c_LAST_BEAT   = BEAT_IDX_BITS'(BEATS - 1);

    adaptor_state_t r_state;
    adaptor_state_t w_state_next;

    logic [BEAT_IDX_BITS-1:0]              r_k;
    logic [ADDR_WIDTH-1:0]                 r_addr;
    // The fill buffer doubles as line_o; write-back data lives in its own
    // register so a write-back never disturbs the last completed fill.
    logic [BEATS-1:0][BURST_WIDTH-1:0]     r_fill;
    logic [BEATS-1:0][BURST_WIDTH-1:0]     r_wb_line;

    logic [ADDR_WIDTH-1:0]                 w_addr_aligned;
    logic                                  w_last_beat;

    assign w_addr_aligned = address_i & ~c_OFFSET_MASK;
    assign w_last_beat    = resp_i && (r_k == c_LAST_BEAT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        read_o       = 1'b0;
        write_o      = 1'b0;
        resp_o       = 1'b0;
        burst_o      = '0;

        unique case (r_state)
            IDLE: begin
                // Write-back wins a tie; the read stays pending at the cache.
                if (write_i) begin
                    w_state_next = WR;
                end else if (read_i) begin
                    w_state_next = RD;
                end
            end
            RD: begin
                read_o = 1'b1;
                if (w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            WR: begin
                write_o = 1'b1;
                burst_o = r_wb_line[r_k];
                if (w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                resp_o       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address latch, beat counter, fill and write-back buffers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k       <= '0;
            r_addr    <= '0;
            r_fill    <= '0;
            r_wb_line <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (write_i) begin
                        r_wb_line <= line_i;
                        r_addr    <= w_addr_aligned;
                        r_k       <= '0;
                    end else if (read_i) begin
                        r_addr    <= w_addr_aligned;
                        r_k       <= '0;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        r_fill[r_k] <= burst_i;
                        r_k         <= r_k + 1'b1;
                    end
                end
                WR: begin
                    if (resp_i) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                    // DONE: nothing moves; late requests are ignored.
                end
            endcase
        end
    end

    assign address_o = r_addr;
    assign line_o    = r_fill;

endmodule : line_burst_adaptor
`default_nettype wire
